// File: rtl/adder_result_checker.sv
// Response checker for a WIDTH-bit adder: recomputes {carry,sum} for each sampled vector,
// counts passes/fails, captures the first failing vector and reports a verdict in DONE.
module adder_result_checker #(
   parameter int WIDTH        = 4,
   parameter int CNT_W        = 16,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH:0]   result,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             fail_seen,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH:0]   fail_got,
   output logic [WIDTH:0]   fail_exp
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_q;
   logic               busy_q, done_q, pass_q, mismatch_q, fail_seen_q;
   logic [CNT_W-1:0]   pass_cnt_q, fail_cnt_q;
   logic [CNT_W-1:0]   pass_cnt_d, fail_cnt_d;
   logic [WIDTH-1:0]   fail_a_q, fail_b_q;
   logic [WIDTH:0]     fail_got_q, fail_exp_q;

   // Stage 1 registers: the sampled vector and its recomputed reference sum
   logic               s1_valid_q;
   logic [WIDTH-1:0]   s1_a_q, s1_b_q;
   logic [WIDTH:0]     s1_res_q, s1_exp_q;
   logic [WIDTH:0]     exp_d;

   logic               cmp_active, cmp_match, cmp_fail;

   assign exp_d = {1'b0, a} + {1'b0, b};

   always_comb begin
      cmp_active = s1_valid_q && ((state_q == S_RUN) || (state_q == S_DRAIN));
      cmp_match  = (s1_res_q == s1_exp_q);
      cmp_fail   = cmp_active && !cmp_match;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if (cmp_active && cmp_match && (pass_cnt_q != {CNT_W{1'b1}}))
         pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (cmp_fail && (fail_cnt_q != {CNT_W{1'b1}}))
         fail_cnt_d = fail_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         mismatch_q  <= 1'b0;
         fail_seen_q <= 1'b0;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         fail_a_q    <= '0;
         fail_b_q    <= '0;
         fail_got_q  <= '0;
         fail_exp_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_res_q    <= '0;
         s1_exp_q    <= '0;
      end else begin
         mismatch_q <= cmp_fail;
         s1_valid_q <= 1'b0;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         // First-fail capture is sticky until the next start/clear/rst
         if (cmp_fail && !fail_seen_q) begin
            fail_seen_q <= 1'b1;
            fail_a_q    <= s1_a_q;
            fail_b_q    <= s1_b_q;
            fail_got_q  <= s1_res_q;
            fail_exp_q  <= s1_exp_q;
         end
         if ((state_q == S_RUN) && sample_valid) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= a;
            s1_b_q     <= b;
            s1_res_q   <= result;
            s1_exp_q   <= exp_d;
         end

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q     <= S_RUN;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_seen_q <= 1'b0;
                  pass_cnt_q  <= '0;
                  fail_cnt_q  <= '0;
                  fail_a_q    <= '0;
                  fail_b_q    <= '0;
                  fail_got_q  <= '0;
                  fail_exp_q  <= '0;
               end
            end
            S_RUN: begin
               if (stop || (STOP_ON_FAIL && cmp_fail))
                  state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               // Verdict uses the counts including the compare finishing this cycle
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= (fail_cnt_d == '0) && (pass_cnt_d != '0);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign mismatch  = mismatch_q;
   assign pass_cnt  = pass_cnt_q;
   assign fail_cnt  = fail_cnt_q;
   assign fail_seen = fail_seen_q;
   assign fail_a    = fail_a_q;
   assign fail_b    = fail_b_q;
   assign fail_got  = fail_got_q;
   assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: default, saturating (CNT_W=3) and
// stop-on-fail instances share one stimulus bus.
module tb_adder_result_checker;

   logic       clk = 1'b0;
   logic       rst, start, stop, clear, sample_valid;
   logic [3:0] a, b;
   logic [4:0] result;

   logic        m_busy, m_done, m_pass, m_mis, m_seen;
   logic [15:0] m_pcnt, m_fcnt;
   logic [3:0]  m_fa, m_fb;
   logic [4:0]  m_fgot, m_fexp;

   logic        s_busy, s_done, s_pass, s_mis, s_seen;
   logic [2:0]  s_pcnt, s_fcnt;
   logic [3:0]  s_fa, s_fb;
   logic [4:0]  s_fgot, s_fexp;

   logic        f_busy, f_done, f_pass, f_mis, f_seen;
   logic [15:0] f_pcnt, f_fcnt;
   logic [3:0]  f_fa, f_fb;
   logic [4:0]  f_fgot, f_fexp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_result_checker dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .sample_valid(sample_valid), .a(a), .b(b), .result(result),
      .busy(m_busy), .done(m_done), .pass(m_pass), .mismatch(m_mis),
      .pass_cnt(m_pcnt), .fail_cnt(m_fcnt), .fail_seen(m_seen),
      .fail_a(m_fa), .fail_b(m_fb), .fail_got(m_fgot), .fail_exp(m_fexp));

   adder_result_checker #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .sample_valid(sample_valid), .a(a), .b(b), .result(result),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mis),
      .pass_cnt(s_pcnt), .fail_cnt(s_fcnt), .fail_seen(s_seen),
      .fail_a(s_fa), .fail_b(s_fb), .fail_got(s_fgot), .fail_exp(s_fexp));

   adder_result_checker #(.STOP_ON_FAIL(1'b1)) dut_sof (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .sample_valid(sample_valid), .a(a), .b(b), .result(result),
      .busy(f_busy), .done(f_done), .pass(f_pass), .mismatch(f_mis),
      .pass_cnt(f_pcnt), .fail_cnt(f_fcnt), .fail_seen(f_seen),
      .fail_a(f_fa), .fail_b(f_fb), .fail_got(f_fgot), .fail_exp(f_fexp));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic [4:0] rv);
      sample_valid = v; a = av; b = bv; result = rv;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      put(1'b0, 4'h0, 4'h0, 5'h00);
      tick(); tick();
      rst = 1'b0;
      checks++; if ({m_busy, m_done, m_pass, m_mis, m_seen} !== 5'b0) begin errors++;
         $display("FAIL reset_flags got %b exp 00000", {m_busy, m_done, m_pass, m_mis, m_seen}); end
      checks++; if ({m_pcnt, m_fcnt, m_fa, m_fb, m_fgot, m_fexp} !== 50'd0) begin errors++;
         $display("FAIL reset_data got %h exp 0", {m_pcnt, m_fcnt, m_fa, m_fb, m_fgot, m_fexp}); end
      put(1'b1, 4'hA, 4'hA, 5'b10100);
      tick(); tick();
      put(1'b0, 4'h0, 4'h0, 5'h00);
      checks++; if (m_pcnt !== 16'd0 || m_busy !== 1'b0) begin errors++;
         $display("FAIL idle_ignore got pass_cnt=%0d busy=%b exp 0 0", m_pcnt, m_busy); end
      $display("test_reset done");
   endtask

   task automatic test_pass_run();
      logic [3:0] va [4] = '{4'b1010, 4'b1100, 4'b1001, 4'b1100};
      logic [3:0] vb [4] = '{4'b1010, 4'b1010, 4'b1110, 4'b1010};
      logic [4:0] vr [4] = '{5'b10100, 5'b10110, 5'b10111, 5'b10110};
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin errors++;
         $display("FAIL run_enter got busy=%b done=%b exp 1 0", m_busy, m_done); end
      for (int i = 0; i < 4; i++) begin
         put(1'b1, va[i], vb[i], vr[i]);
         tick();
         checks++; if (m_pcnt !== 16'(i)) begin errors++;
            $display("FAIL run_latency[%0d] got %0d exp %0d", i, m_pcnt, i); end
      end
      put(1'b0, 4'h0, 4'h0, 5'h00);
      tick();
      checks++; if (m_pcnt !== 16'd4 || m_fcnt !== 16'd0) begin errors++;
         $display("FAIL run_counts got pass=%0d fail=%0d exp 4 0", m_pcnt, m_fcnt); end
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin errors++;
         $display("FAIL drain_state got busy=%b done=%b exp 1 0", m_busy, m_done); end
      tick();
      checks++; if ({m_busy, m_done, m_pass} !== 3'b011) begin errors++;
         $display("FAIL run_verdict got busy/done/pass=%b exp 011", {m_busy, m_done, m_pass}); end
      $display("test_pass_run done");
   endtask

   task automatic test_first_fail();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (m_pcnt !== 16'd0 || m_done !== 1'b0 || m_pass !== 1'b0) begin errors++;
         $display("FAIL restart_clear got pass_cnt=%0d done=%b pass=%b exp 0 0 0", m_pcnt, m_done, m_pass); end
      put(1'b1, 4'b1001, 4'b1110, 5'b00111);
      tick();
      checks++; if (m_mis !== 1'b0) begin errors++;
         $display("FAIL mis_early got %b exp 0", m_mis); end
      put(1'b1, 4'b1111, 4'b0001, 5'b00000);
      tick();
      checks++; if (m_mis !== 1'b1 || m_fcnt !== 16'd1 || m_seen !== 1'b1) begin errors++;
         $display("FAIL first_fail got mis=%b fail=%0d seen=%b exp 1 1 1", m_mis, m_fcnt, m_seen); end
      checks++; if ({m_fa, m_fb, m_fexp, m_fgot} !== {4'b1001, 4'b1110, 5'b10111, 5'b00111}) begin errors++;
         $display("FAIL capture got a=%b b=%b exp=%b got=%b exp 1001 1110 10111 00111", m_fa, m_fb, m_fexp, m_fgot); end
      put(1'b0, 4'h0, 4'h0, 5'h00);
      tick();
      checks++; if (m_mis !== 1'b1 || m_fcnt !== 16'd2) begin errors++;
         $display("FAIL second_fail got mis=%b fail=%0d exp 1 2", m_mis, m_fcnt); end
      checks++; if ({m_fa, m_fb, m_fexp, m_fgot} !== {4'b1001, 4'b1110, 5'b10111, 5'b00111}) begin errors++;
         $display("FAIL capture_hold got a=%b b=%b exp=%b got=%b", m_fa, m_fb, m_fexp, m_fgot); end
      tick();
      checks++; if (m_mis !== 1'b0) begin errors++;
         $display("FAIL mis_pulse_width got %b exp 0", m_mis); end
      stop = 1'b1; tick(); stop = 1'b0; tick();
      checks++; if (m_done !== 1'b1 || m_pass !== 1'b0) begin errors++;
         $display("FAIL fail_verdict got done=%b pass=%b exp 1 0", m_done, m_pass); end
      $display("test_first_fail done");
   endtask

   task automatic test_carry();
      start = 1'b1; tick(); start = 1'b0;
      put(1'b1, 4'b1111, 4'b1111, 5'b11110); tick();
      put(1'b1, 4'b1111, 4'b1111, 5'b01110); tick();
      checks++; if (m_pcnt !== 16'd1 || m_fcnt !== 16'd0) begin errors++;
         $display("FAIL carry_pass got pass=%0d fail=%0d exp 1 0", m_pcnt, m_fcnt); end
      put(1'b0, 4'h0, 4'h0, 5'h00); tick();
      checks++; if (m_fcnt !== 16'd1 || m_fgot !== 5'b01110 || m_fexp !== 5'b11110) begin errors++;
         $display("FAIL carry_drop got fail=%0d got=%b exp=%b exp 1 01110 11110", m_fcnt, m_fgot, m_fexp); end
      $display("test_carry done");
   endtask

   task automatic test_saturation();
      clear = 1'b1; tick(); clear = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         put(1'b1, 4'(i), 4'd3, 5'(i + 3));
         tick();
      end
      put(1'b0, 4'h0, 4'h0, 5'h00); tick();
      checks++; if (s_pcnt !== 3'd7) begin errors++;
         $display("FAIL saturate got %0d exp 7", s_pcnt); end
      checks++; if (m_pcnt !== 16'd10) begin errors++;
         $display("FAIL wide_count got %0d exp 10", m_pcnt); end
      stop = 1'b1; tick(); stop = 1'b0; tick();
      checks++; if (s_done !== 1'b1 || s_pass !== 1'b1 || s_pcnt !== 3'd7) begin errors++;
         $display("FAIL sat_verdict got done=%b pass=%b cnt=%0d exp 1 1 7", s_done, s_pass, s_pcnt); end
      $display("test_saturation done");
   endtask

   task automatic test_stop_on_fail();
      clear = 1'b1; tick(); clear = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      put(1'b1, 4'b0011, 4'b0100, 5'b00110); tick();
      put(1'b0, 4'h0, 4'h0, 5'h00); tick();
      checks++; if (f_busy !== 1'b1 || f_done !== 1'b0 || f_mis !== 1'b1 || f_fcnt !== 16'd1) begin errors++;
         $display("FAIL sof_drain got busy=%b done=%b mis=%b fail=%0d exp 1 0 1 1", f_busy, f_done, f_mis, f_fcnt); end
      tick();
      checks++; if (f_done !== 1'b1 || f_busy !== 1'b0 || f_pass !== 1'b0) begin errors++;
         $display("FAIL sof_done got done=%b busy=%b pass=%b exp 1 0 0", f_done, f_busy, f_pass); end
      checks++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin errors++;
         $display("FAIL no_sof_keeps_running got busy=%b done=%b exp 1 0", m_busy, m_done); end
      $display("test_stop_on_fail done");
   endtask

   task automatic test_abort(input bit use_rst);
      clear = 1'b1; tick(); clear = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      put(1'b1, 4'b0101, 4'b0101, 5'b00000); tick();
      if (use_rst) rst = 1'b1; else clear = 1'b1;
      put(1'b1, 4'b0110, 4'b0001, 5'b00000); tick();
      rst = 1'b0; clear = 1'b0;
      checks++; if (m_busy !== 1'b0 || m_fcnt !== 16'd0 || m_mis !== 1'b0 || m_seen !== 1'b0) begin errors++;
         $display("FAIL abort_%s got busy=%b fail=%0d mis=%b seen=%b exp 0 0 0 0",
                  use_rst ? "rst" : "clear", m_busy, m_fcnt, m_mis, m_seen); end
      put(1'b0, 4'h0, 4'h0, 5'h00); tick();
      checks++; if (m_mis !== 1'b0 || m_fcnt !== 16'd0 || m_pcnt !== 16'd0) begin errors++;
         $display("FAIL abort_after_%s got mis=%b fail=%0d pass=%0d exp 0 0 0",
                  use_rst ? "rst" : "clear", m_mis, m_fcnt, m_pcnt); end
      $display("test_abort(%0d) done", use_rst);
   endtask

   initial begin
      test_reset();
      test_pass_run();
      test_first_fail();
      test_carry();
      test_saturation();
      test_stop_on_fail();
      test_abort(1'b1);
      test_abort(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
